pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised hazard and pipeline-control unit for the 5-stage MIPS core. It generates per-stage stall and flush signals and operand-forwarding selects. Compared with the core's existing hazard logic, it adds a multi-cycle MDU (mult/div) wait FSM, precise exception flush, a forwarding-disable mode, and a saturating stall-cycle counter. It sits between controller and datapath, fed by decoded register fields from the D/E/M/W stages.

## Interface
- REG_W, 5, register-index width
- FWD_EN, 1, 1 = forwarding enabled; 0 = forwarding disabled, all RAW hazards resolved by stalling
- CNT_W, 32, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rsD, rtD  in  REG_W  decode source regs
- branchD, jrD  in  1  branch / jump-register in decode
- rsE, rtE, writeregE  in  REG_W  execute sources / destination
- regwriteE, memtoregE  in  1  E writes reg / E is load
- mdu_startE  in  1  multi-cycle MDU op issued from E (level while op sits in E)
- mdu_doneE  in  1  MDU result valid this cycle
- writeregM, regwriteM, memtoregM  in  REG_W,1,1  memory-stage destination info
- excM  in  1  exception raised by instruction in M
- writeregW, regwriteW  in  REG_W,1  writeback destination info
- cnt_clr  in  1  synchronous clear of stall_cnt
- stallF, stallD, stallE, stallM, stallW  out  1  stage hold
- flushD, flushE, flushM, flushW  out  1  stage bubble
- fwdAD, fwdBD  out  1  decode compare operand from M
- fwdAE, fwdBE  out  2  execute operand select: 00 regfile, 01 W, 10 M
- lwstallD, branchstallD, mdu_stall  out  1  stall cause flags
- mdu_cancel  out  1  one-cycle MDU abort
- stall_cnt  out  CNT_W  saturating count of cycles with stallF=1

## Operation
- Match rule: a write to register 0 never matches. "dst(X)" means regwriteX && writeregX!=0.
- Forwarding (FWD_EN=1):
  - fwdAE=10 if dst(M) && writeregM==rsE; else 01 if dst(W) && writeregW==rsE; else 00. fwdBE is the same using rtE.
  - fwdAD=dst(M) && writeregM==rsD. fwdBD is the same using rtD.
- FWD_EN=0: all fwd outputs are 0. lwstallD is additionally asserted on any dst(E) or dst(M) match against rsD/rtD.
- lwstallD = memtoregE && rtE!=0 && (rtE==rsD || rtE==rtD).
- branchstallD = (branchD && (dst(E) match rsD/rtD || (memtoregM && writeregM!=0 && match rsD/rtD))) || (jrD && the same test on rsD only).
- FSM states (in package): RUN, MDU_WAIT.
  - RUN -> MDU_WAIT when mdu_startE && !mdu_doneE && !excM.
  - MDU_WAIT -> RUN when mdu_doneE or excM.
- mdu_stall = mdu_startE && !mdu_doneE (in RUN or MDU_WAIT).
- Priority and outputs, highest first:
  - excM: flushD/E/M/W=1, all stalls 0. mdu_cancel=1 if state==MDU_WAIT or mdu_startE.
  - mdu_stall: stallF/D/E=1, flushM=1. lwstall/branchstall are masked; their flags still read out.
  - lwstallD|branchstallD: stallF/D=1, flushE=1.
  - Otherwise: all stalls and flushes 0.
- stallM and stallW are always 0. The ports are reserved for future memory wait states.
- stall_cnt: increments when stallF=1 and saturates at all-ones. cnt_clr takes priority over increment.

## Timing
- All stall/flush/fwd/flag outputs are combinational from inputs and the registered state: same-cycle response.
- Registered elements: FSM state, stall_cnt.
- During reset (rst=0): state=RUN, stall_cnt=0, and all outputs are forced to 0 regardless of inputs.
- Deassertion takes effect at the first rising edge after rst=1.
- Case mdu_startE && mdu_doneE in RUN (single-cycle MDU op): no stall, state stays RUN.
- Case mdu_doneE in MDU_WAIT: stalls drop in that same cycle and the next state is RUN.
- Case excM during MDU_WAIT: mdu_cancel pulses exactly one cycle and the next state is RUN.
- Case cnt_clr with stallF in the same cycle: the counter becomes 0, not 1.
- Reset asserted mid-MDU_WAIT: state returns to RUN immediately (asynchronous) and mdu_cancel stays 0.

## Structure
- Package hazard_ctrl_pkg holds:
  - state enum {RUN, MDU_WAIT};
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module: fwd_sel. It compares one source index against M/W destinations and returns a 2-bit select; instantiated four times, with D-stage use taking bit 1 only.
- The FSM and counter live in the top module.

## Test plan
- Load-use: memtoregE=1, rtE=8, rsD=8 -> lwstallD=1, stallF=stallD=1, flushE=1. The next cycle with memtoregE=0 -> all 0.
- Forwarding priority: regwriteM=1, writeregM=9; regwriteW=1, writeregW=9; rsE=9 -> fwdAE=10. Set writeregM=0 -> fwdAE=01.
- MDU: mdu_startE high 4 cycles, mdu_doneE on the 4th -> stallF/D/E=1 and flushM=1 for cycles 1-3, 0 on cycle 4. state is MDU_WAIT for cycles 2-4, RUN after.
- Exception mid-MDU: excM on cycle 2 of the wait -> flushD/E/M/W=1, stalls 0, mdu_cancel=1 for one cycle, next state RUN.
- FWD_EN=0: regwriteE=1, writeregE=5, rtD=5 -> lwstallD=1, fwd outputs 0. Same with writeregE=0 -> no stall.
- Counter: CNT_W=4, hold a stall 20 cycles -> stall_cnt saturates at 15. cnt_clr with stallF=1 -> 0. Async reset mid-stall -> 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard/control unit:
//   hz_state_e : MDU wait FSM states
//   FWD_*      : execute-stage operand forward selects
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the controller/datapath (master) and the hazard unit
// (slave). Master drives the decoded register fields of the D/E/M/W stages
// plus MDU/exception status; slave returns stall/flush controls, forwarding
// selects, cause flags and the stall-cycle counter.
// Parameters REG_W / CNT_W must match the hazard unit instance.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  // decode
  logic [REG_W-1:0] rsD, rtD;
  logic             branchD, jrD;
  // execute
  logic [REG_W-1:0] rsE, rtE, writeregE;
  logic             regwriteE, memtoregE;
  logic             mdu_startE, mdu_doneE;
  // memory
  logic [REG_W-1:0] writeregM;
  logic             regwriteM, memtoregM;
  logic             excM;
  // writeback
  logic [REG_W-1:0] writeregW;
  logic             regwriteW;
  // counter control
  logic             cnt_clr;
  // hazard unit outputs
  logic             stallF, stallD, stallE, stallM, stallW;
  logic             flushD, flushE, flushM, flushW;
  logic             fwdAD, fwdBD;
  logic [1:0]       fwdAE, fwdBE;
  logic             lwstallD, branchstallD, mdu_stall;
  logic             mdu_cancel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rsD, rtD, branchD, jrD,
    output rsE, rtE, writeregE, regwriteE, memtoregE, mdu_startE, mdu_doneE,
    output writeregM, regwriteM, memtoregM, excM,
    output writeregW, regwriteW, cnt_clr,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushD, flushE, flushM, flushW,
    input  fwdAD, fwdBD, fwdAE, fwdBE,
    input  lwstallD, branchstallD, mdu_stall, mdu_cancel, stall_cnt
  );

  modport slave (
    input  rsD, rtD, branchD, jrD,
    input  rsE, rtE, writeregE, regwriteE, memtoregE, mdu_startE, mdu_doneE,
    input  writeregM, regwriteM, memtoregM, excM,
    input  writeregW, regwriteW, cnt_clr,
    output stallF, stallD, stallE, stallM, stallW,
    output flushD, flushE, flushM, flushW,
    output fwdAD, fwdBD, fwdAE, fwdBE,
    output lwstallD, branchstallD, mdu_stall, mdu_cancel, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Compares one source register index against the M and W destinations and
// returns a forward select. M wins over W because it holds the younger
// result. Writes to register 0 never match.
//   src_i               : source register index
//   wreg_m_i/regwr_m_i  : memory-stage destination and write enable
//   wreg_w_i/regwr_w_i  : writeback-stage destination and write enable
//   sel_o               : FWD_M / FWD_W / FWD_RF
// ---------------------------------------------------------------------------
module fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] wreg_m_i,
  input  logic             regwr_m_i,
  input  logic [REG_W-1:0] wreg_w_i,
  input  logic             regwr_w_i,
  output logic [1:0]       sel_o
);

  logic hit_m, hit_w;

  assign hit_m = regwr_m_i && (wreg_m_i != '0) && (wreg_m_i == src_i);
  assign hit_w = regwr_w_i && (wreg_w_i != '0) && (wreg_w_i == src_i);

  always_comb begin
    sel_o = FWD_RF;
    if (hit_m)      sel_o = FWD_M;
    else if (hit_w) sel_o = FWD_W;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and pipeline-control unit for the 5-stage core. Produces per-stage
// stall/flush, operand forwarding selects, stall cause flags, a one-cycle
// MDU abort and a saturating count of fetch-stall cycles.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset; while low every output reads 0
//   hz   : slave side of pipe_hazard_ctrl_if (stage fields in, controls out)
// Parameters: REG_W register index width, FWD_EN forwarding enable
// (0 = resolve every RAW hazard by stalling), CNT_W stall counter width.
// All controls are combinational from inputs and the registered FSM state.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic dstE, loadM;
  logic hitE_s, hitE_t, hitM_s, hitM_t, loadM_s, loadM_t;
  logic lw_raw, br_raw, mdu_raw;
  logic [1:0] selAE, selBE, selAD, selBD;
  logic unused_d_bits;

  // Forwarding selects; decode comparators only need the M bit.
  fwd_sel #(.REG_W(REG_W)) u_fwd_ae (
    .src_i(hz.rsE), .wreg_m_i(hz.writeregM), .regwr_m_i(hz.regwriteM),
    .wreg_w_i(hz.writeregW), .regwr_w_i(hz.regwriteW), .sel_o(selAE));
  fwd_sel #(.REG_W(REG_W)) u_fwd_be (
    .src_i(hz.rtE), .wreg_m_i(hz.writeregM), .regwr_m_i(hz.regwriteM),
    .wreg_w_i(hz.writeregW), .regwr_w_i(hz.regwriteW), .sel_o(selBE));
  fwd_sel #(.REG_W(REG_W)) u_fwd_ad (
    .src_i(hz.rsD), .wreg_m_i(hz.writeregM), .regwr_m_i(hz.regwriteM),
    .wreg_w_i(hz.writeregW), .regwr_w_i(hz.regwriteW), .sel_o(selAD));
  fwd_sel #(.REG_W(REG_W)) u_fwd_bd (
    .src_i(hz.rtD), .wreg_m_i(hz.writeregM), .regwr_m_i(hz.regwriteM),
    .wreg_w_i(hz.writeregW), .regwr_w_i(hz.regwriteW), .sel_o(selBD));

  assign unused_d_bits = ^{selAD[0], selBD[0]};

  // Destination matches against the decode sources.
  assign dstE    = hz.regwriteE && (hz.writeregE != '0);
  assign loadM   = hz.memtoregM && (hz.writeregM != '0);
  assign hitE_s  = dstE && (hz.writeregE == hz.rsD);
  assign hitE_t  = dstE && (hz.writeregE == hz.rtD);
  assign hitM_s  = hz.regwriteM && (hz.writeregM != '0) && (hz.writeregM == hz.rsD);
  assign hitM_t  = hz.regwriteM && (hz.writeregM != '0) && (hz.writeregM == hz.rtD);
  assign loadM_s = loadM && (hz.writeregM == hz.rsD);
  assign loadM_t = loadM && (hz.writeregM == hz.rtD);

  // Without forwarding, any in-flight producer of a decode source must stall.
  assign lw_raw = (hz.memtoregE && (hz.rtE != '0) &&
                   ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD))) ||
                  (!FWD_EN && (hitE_s || hitE_t || hitM_s || hitM_t));

  // jr only reads rs, so rt is ignored for it.
  assign br_raw = (hz.branchD && (hitE_s || hitE_t || loadM_s || loadM_t)) ||
                  (hz.jrD && (hitE_s || loadM_s));

  assign mdu_raw = hz.mdu_startE && !hz.mdu_doneE;

  always_comb begin
    hz.stallF       = 1'b0;
    hz.stallD       = 1'b0;
    hz.stallE       = 1'b0;
    hz.stallM       = 1'b0;
    hz.stallW       = 1'b0;
    hz.flushD       = 1'b0;
    hz.flushE       = 1'b0;
    hz.flushM       = 1'b0;
    hz.flushW       = 1'b0;
    hz.fwdAD        = 1'b0;
    hz.fwdBD        = 1'b0;
    hz.fwdAE        = FWD_RF;
    hz.fwdBE        = FWD_RF;
    hz.lwstallD     = 1'b0;
    hz.branchstallD = 1'b0;
    hz.mdu_stall    = 1'b0;
    hz.mdu_cancel   = 1'b0;
    if (rst) begin
      hz.lwstallD     = lw_raw;
      hz.branchstallD = br_raw;
      hz.mdu_stall    = mdu_raw;
      if (FWD_EN) begin
        hz.fwdAE = selAE;
        hz.fwdBE = selBE;
        hz.fwdAD = selAD[1];
        hz.fwdBD = selBD[1];
      end
      // Exception beats MDU wait, which beats decode hazards.
      if (hz.excM) begin
        hz.flushD     = 1'b1;
        hz.flushE     = 1'b1;
        hz.flushM     = 1'b1;
        hz.flushW     = 1'b1;
        hz.mdu_cancel = (state_q == MDU_WAIT) || hz.mdu_startE;
      end else if (mdu_raw) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.flushM = 1'b1;
      end else if (lw_raw || br_raw) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.flushE = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (hz.mdu_startE && !hz.mdu_doneE && !hz.excM) state_d = MDU_WAIT;
      MDU_WAIT: if (hz.mdu_doneE || hz.excM)                    state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Clear wins over increment; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (hz.cnt_clr)                  cnt_d = '0;
    else if (hz.stallF && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.stall_cnt = cnt_q;

endmodule
